// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : clock_display_scan
// Description : Six-digit multiplexed HH:MM:SS seven-segment driver with a
//               once-per-frame binary-to-BCD conversion (subtract-by-10 FSM).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_display_scan #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic        LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sec,
    input  logic [15:0] min,
    input  logic [15:0] hour,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        dp
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CONV_S = 3'd2,
        ST_CONV_M = 3'd3,
        ST_CONV_H = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    localparam logic [15:0] c_div_last   = SCAN_DIV - 16'd1;
    localparam logic [6:0]  c_seg_dash   = 7'b0111111;
    localparam logic [6:0]  c_seg_blank  = 7'b1111111;

    state_t           r_state_q, r_state_d;
    logic [15:0]      r_prescale_q, r_prescale_d;
    logic [2:0]       r_idx_q, r_idx_d;
    logic             r_pend_q, r_pend_d;
    logic [2:0][15:0] r_val_q, r_val_d;
    logic [2:0][3:0]  r_tens_q, r_tens_d;
    logic [2:0][3:0]  r_ones_q, r_ones_d;
    logic [2:0]       r_oor_q, r_oor_d;
    logic [2:0][3:0]  r_disp_tens_q, r_disp_tens_d;
    logic [2:0][3:0]  r_disp_ones_q, r_disp_ones_d;
    logic [2:0]       r_disp_oor_q, r_disp_oor_d;
    logic [6:0]       r_seg_q, r_seg_d;
    logic [5:0]       r_an_q, r_an_d;
    logic             r_dp_q, r_dp_d;

    logic             w_wrap;
    logic             w_frame_evt;
    logic [1:0]       w_fld;
    logic             w_adv;
    logic [3:0]       w_dig;
    logic             w_dash;
    logic             w_blank;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = c_seg_blank;
        endcase
    endfunction

    always_comb begin
        w_wrap       = (r_prescale_q == c_div_last);
        w_frame_evt  = w_wrap && (r_idx_q == 3'd5);
        r_prescale_d = w_wrap ? 16'd0 : r_prescale_q + 16'd1;
        r_idx_d      = r_idx_q;
        if (w_wrap) begin
            r_idx_d = (r_idx_q == 3'd5) ? 3'd0 : r_idx_q + 3'd1;
        end
    end

    // A frame start is latched so the one after reset (or any that lands
    // while busy) is not lost.
    always_comb begin
        r_state_d     = r_state_q;
        r_pend_d      = r_pend_q | w_frame_evt;
        r_val_d       = r_val_q;
        r_tens_d      = r_tens_q;
        r_ones_d      = r_ones_q;
        r_oor_d       = r_oor_q;
        r_disp_tens_d = r_disp_tens_q;
        r_disp_ones_d = r_disp_ones_q;
        r_disp_oor_d  = r_disp_oor_q;
        w_adv         = 1'b0;
        case (r_state_q)
            ST_CONV_M: w_fld = 2'd1;
            ST_CONV_H: w_fld = 2'd2;
            default:   w_fld = 2'd0;
        endcase

        case (r_state_q)
            ST_IDLE: begin
                if (r_pend_q || w_frame_evt) begin
                    r_pend_d  = 1'b0;
                    r_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                r_val_d   = {hour, min, sec};
                r_tens_d  = '0;
                r_ones_d  = '0;
                r_oor_d   = '0;
                r_state_d = ST_CONV_S;
            end
            ST_CONV_S, ST_CONV_M, ST_CONV_H: begin
                for (int f = 0; f < 3; f++) begin
                    if (2'(f) == w_fld) begin
                        if (r_val_q[f] > 16'd99) begin
                            r_oor_d[f] = 1'b1;
                            w_adv      = 1'b1;
                        end else if (r_val_q[f] >= 16'd10) begin
                            r_val_d[f]  = r_val_q[f] - 16'd10;
                            r_tens_d[f] = r_tens_q[f] + 4'd1;
                        end else begin
                            r_ones_d[f] = r_val_q[f][3:0];
                            w_adv       = 1'b1;
                        end
                    end
                end
                if (w_adv) begin
                    case (r_state_q)
                        ST_CONV_S: r_state_d = ST_CONV_M;
                        ST_CONV_M: r_state_d = ST_CONV_H;
                        default:   r_state_d = ST_COMMIT;
                    endcase
                end
            end
            ST_COMMIT: begin
                r_disp_tens_d = r_tens_q;
                r_disp_ones_d = r_ones_q;
                r_disp_oor_d  = r_oor_q;
                r_state_d     = ST_IDLE;
            end
            default: r_state_d = ST_IDLE;
        endcase
    end

    // Even indices carry ones digits, odd indices tens digits.
    always_comb begin
        w_dig   = r_disp_ones_q[0];
        w_dash  = r_disp_oor_q[0];
        w_blank = 1'b0;
        case (r_idx_q)
            3'd1: w_dig = r_disp_tens_q[0];
            3'd2: begin w_dig = r_disp_ones_q[1]; w_dash = r_disp_oor_q[1]; end
            3'd3: begin w_dig = r_disp_tens_q[1]; w_dash = r_disp_oor_q[1]; end
            3'd4: begin w_dig = r_disp_ones_q[2]; w_dash = r_disp_oor_q[2]; end
            3'd5: begin
                w_dig   = r_disp_tens_q[2];
                w_dash  = r_disp_oor_q[2];
                w_blank = LZ_BLANK && (r_disp_tens_q[2] == 4'd0) && !r_disp_oor_q[2];
            end
            default: ;
        endcase
        r_seg_d = w_dash ? c_seg_dash : (w_blank ? c_seg_blank : f_seg(w_dig));
        r_an_d  = ~(6'd1 << r_idx_q);
        r_dp_d  = !((r_idx_q == 3'd2) || (r_idx_q == 3'd4));
        if (!enable) begin
            r_seg_d = c_seg_blank;
            r_an_d  = 6'b111111;
            r_dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= ST_IDLE;
            r_prescale_q  <= 16'd0;
            r_idx_q       <= 3'd0;
            r_pend_q      <= 1'b1;
            r_val_q       <= '0;
            r_tens_q      <= '0;
            r_ones_q      <= '0;
            r_oor_q       <= '0;
            r_disp_tens_q <= '0;
            r_disp_ones_q <= '0;
            r_disp_oor_q  <= '0;
            r_seg_q       <= c_seg_blank;
            r_an_q        <= 6'b111111;
            r_dp_q        <= 1'b1;
        end else begin
            r_state_q     <= r_state_d;
            r_prescale_q  <= r_prescale_d;
            r_idx_q       <= r_idx_d;
            r_pend_q      <= r_pend_d;
            r_val_q       <= r_val_d;
            r_tens_q      <= r_tens_d;
            r_ones_q      <= r_ones_d;
            r_oor_q       <= r_oor_d;
            r_disp_tens_q <= r_disp_tens_d;
            r_disp_ones_q <= r_disp_ones_d;
            r_disp_oor_q  <= r_disp_oor_d;
            r_seg_q       <= r_seg_d;
            r_an_q        <= r_an_d;
            r_dp_q        <= r_dp_d;
        end
    end

    assign seg = r_seg_q;
    assign an  = r_an_q;
    assign dp  = r_dp_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_display_scan
// Description : Randomised self-checking bench for clock_display_scan against
//               an arithmetic model of the six-digit scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_display_scan;

    localparam int DIV   = 40;
    localparam int FRAME = DIV * 6;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sec    = 16'd0;
    logic [15:0] min    = 16'd0;
    logic [15:0] hour   = 16'd0;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        dp;

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    logic [13:0] obs [6];

    clock_display_scan #(.SCAN_DIV(16'd40), .LZ_BLANK(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sec    (sec),
        .min    (min),
        .hour   (hour),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    // Active (non-reset) edges since the last reset edge.
    always @(posedge clk) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Returns {an, seg, dp} for one slot of a frame showing s:m:h.
    function automatic logic [13:0] model(input int slot, input int s, input int m,
                                          input int h, input logic en);
        int v;
        int d;
        logic [6:0] sg;
        logic [5:0] a;
        logic p;
        if (!en) return {6'b111111, 7'b1111111, 1'b1};
        v = (slot < 2) ? s : ((slot < 4) ? m : h);
        d = (slot % 2 == 0) ? v % 10 : v / 10;
        if (v > 99)                    sg = 7'b0111111;
        else if (slot == 5 && d == 0)  sg = 7'b1111111;
        else                           sg = digit_code(d);
        a = ~(6'd1 << slot);
        p = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
        return {a, sg, p};
    endfunction

    task automatic wait_phase(input int ph);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % FRAME) != ph && n < 2 * FRAME);
        if ((k % FRAME) != ph) begin
            checks++;
            failures++;
            $display("FAIL wait_phase: phase=%0d required=%0d", k % FRAME, ph);
        end
    endtask

    // Captures every slot near the end of its dwell, after the frame's commit.
    task automatic sample_frame();
        for (int s = 0; s < 6; s++) begin
            wait_phase(s * DIV + DIV - 1);
            obs[s] = {an, seg, dp};
        end
    endtask

    task automatic apply(input int s, input int m, input int h);
        wait_phase(100);
        sec  = 16'(s);
        min  = 16'(m);
        hour = 16'(h);
    endtask

    task automatic test_reset();
        logic [13:0] exp_v;
        rst = 1'b0;
        enable = 1'b1;
        sec = 16'd12; min = 16'd34; hour = 16'd21;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 6'b111111) begin failures++; $display("FAIL reset_an: got=%b exp=%b", an, 6'b111111); end
        checks++;
        if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg: got=%b exp=%b", seg, 7'b1111111); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got=%b exp=%b", dp, 1'b1); end
        rst = 1'b1;
        @(negedge clk);
        exp_v = model(0, 0, 0, 0, 1'b1);
        checks++;
        if ({an, seg, dp} !== exp_v) begin
            failures++;
            $display("FAIL reset_zero_display: got=%b exp=%b", {an, seg, dp}, exp_v);
        end
    endtask

    task automatic test_basic();
        logic [13:0] exp_v;
        apply(37, 5, 9);
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, 37, 5, 9, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL basic_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
    endtask

    task automatic test_sec99();
        logic [13:0] exp_v;
        wait_phase(100);
        sec = 16'd99; min = 16'd99; hour = 16'd99;
        wait_phase(34);
        exp_v = model(0, 99, 99, 99, 1'b1);
        checks++;
        if ({an, seg, dp} !== exp_v) begin
            failures++;
            $display("FAIL sec99_latency: got=%b exp=%b", {an, seg, dp}, exp_v);
        end
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, 99, 99, 99, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL sec99_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
    endtask

    task automatic test_hour120();
        logic [13:0] exp_v;
        int s_v = int'($urandom_range(0, 99));
        int m_v = int'($urandom_range(0, 99));
        apply(s_v, m_v, 120);
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, s_v, m_v, 120, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL hour120_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] exp_v;
        for (int it = 0; it < 6; it++) begin
            int s_v = int'($urandom_range(0, 110));
            int m_v = int'($urandom_range(0, 110));
            int h_v = (it % 2 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 130));
            apply(s_v, m_v, h_v);
            sample_frame();
            for (int s = 0; s < 6; s++) begin
                exp_v = model(s, s_v, m_v, h_v, 1'b1);
                checks++;
                if (obs[s] !== exp_v) begin
                    failures++;
                    $display("FAIL random%0d_slot%0d: in=%0d/%0d/%0d got=%b exp=%b",
                             it, s, s_v, m_v, h_v, obs[s], exp_v);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [13:0] exp_v;
        apply(10, 44, 12);
        wait_phase(5);
        sec = 16'd11;
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, 10, 44, 12, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL snapshot_old_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, 11, 44, 12, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL snapshot_new_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
    endtask

    task automatic test_enable();
        logic [13:0] exp_v;
        int slot;
        int dark_bad = 0;
        apply(23, 58, 17);
        sample_frame();
        wait_phase(100);
        enable = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
                failures++;
                if (dark_bad < 3) $display("FAIL enable_dark c=%0d: got=%b exp=%b", c, {an, seg, dp},
                                           {6'b111111, 7'b1111111, 1'b1});
                dark_bad++;
            end
        end
        enable = 1'b1;
        @(negedge clk);
        slot = ((k - 1) / DIV) % 6;
        exp_v = model(slot, 23, 58, 17, 1'b1);
        checks++;
        if ({an, seg, dp} !== exp_v) begin
            failures++;
            $display("FAIL enable_resume slot%0d: got=%b exp=%b", slot, {an, seg, dp}, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp_v;
        apply(59, 59, 23);
        wait_phase(10);
        rst = 1'b0;
        sec = 16'd42; min = 16'd17; hour = 16'd3;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
            failures++;
            $display("FAIL midreset_dark: got=%b exp=%b", {an, seg, dp}, {6'b111111, 7'b1111111, 1'b1});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_v = model(0, 0, 0, 0, 1'b1);
        checks++;
        if ({an, seg, dp} !== exp_v) begin
            failures++;
            $display("FAIL midreset_zero: got=%b exp=%b", {an, seg, dp}, exp_v);
        end
        sample_frame();
        for (int s = 0; s < 6; s++) begin
            exp_v = model(s, 42, 17, 3, 1'b1);
            checks++;
            if (obs[s] !== exp_v) begin
                failures++;
                $display("FAIL midreset_slot%0d: got=%b exp=%b", s, obs[s], exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sec99();
        test_hour120();
        test_random();
        test_snapshot();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
